// File: rtl/regfile_psr.sv
// ---------------------------------------------------------------------------
// regfile_psr
//
// Operand-supply and state-holding stage in front of the ALU. Holds the
// general-purpose register file and the processor status register (PSR).
//
// Ports
//   clk       : system clock, all state changes on the rising edge
//   reset     : synchronous, active-high; clears every register and the PSR
//   src_sel   : register index presented on r1_out (ALU source operand R1)
//   dst_sel   : register index presented on r2_out (ALU destination operand R2)
//   r1_out    : source operand, combinational, with write-through bypass
//   r2_out    : destination operand, combinational, with write-through bypass
//   wr_en     : register write enable
//   wr_sel    : register index to write
//   wr_data   : writeback data (ALU result or load data)
//   flags_in  : ALU flags {Z, N, F, L, C} (bit0 = C)
//   flags_we  : per-bit PSR write mask
//   psr       : latched PSR
//   cin       : ALU carry-in, the latched PSR carry bit (no bypass)
//   dbg_sel   : debug read index
//   dbg_out   : raw stored contents of reg[dbg_sel], never bypassed
// ---------------------------------------------------------------------------
module regfile_psr #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 16,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] src_sel,
    input  logic [ADDR_W-1:0] dst_sel,
    output logic [DATA_W-1:0] r1_out,
    output logic [DATA_W-1:0] r2_out,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [FLAG_W-1:0] flags_we,
    output logic [FLAG_W-1:0] psr,
    output logic              cin,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_out
);

    // Storage. NREGS equals 2**ADDR_W, so every select value addresses a
    // real entry and no out-of-range handling is required.
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [FLAG_W-1:0] psr_q;
    logic [FLAG_W-1:0] psr_d;

    // Per-port bypass hits: the port sees the value being written this cycle.
    logic              r1_hit_s;
    logic              r2_hit_s;

    // Next-state of the register file: only the selected entry takes wr_data.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wr_sel] = wr_data;
        end else begin
            regs_d[wr_sel] = regs_q[wr_sel];
        end
    end

    // Next-state of the PSR: each bit independently loads or holds.
    always_comb begin
        psr_d = psr_q;
        for (int i = 0; i < FLAG_W; i++) begin
            if (flags_we[i]) begin
                psr_d[i] = flags_in[i];
            end else begin
                psr_d[i] = psr_q[i];
            end
        end
    end

    // State update; reset wins over any write or flag update in the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            psr_q <= {FLAG_W{1'b0}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            psr_q <= psr_d;
        end
    end

    // Bypass detection. The bypass follows wr_en alone, so a write presented
    // during a reset cycle is still visible on the operand ports that cycle
    // even though the edge then discards it.
    always_comb begin
        r1_hit_s = wr_en && (wr_sel == src_sel);
        r2_hit_s = wr_en && (wr_sel == dst_sel);
    end

    // Operand read ports with write-through bypass.
    always_comb begin
        if (r1_hit_s) begin
            r1_out = wr_data;
        end else begin
            r1_out = regs_q[src_sel];
        end
        if (r2_hit_s) begin
            r2_out = wr_data;
        end else begin
            r2_out = regs_q[dst_sel];
        end
    end

    // Debug port and status outputs come straight from stored state. cin is
    // deliberately not bypassed from flags_in: a carry must have been latched
    // on an earlier edge before ADDC/SUBC can consume it.
    always_comb begin
        dbg_out = regs_q[dbg_sel];
        psr     = psr_q;
        cin     = psr_q[0];
    end

endmodule

// File: doc/regfile_psr.md
Name: regfile_psr

Overview:
- Operand-supply and state-holding stage directly upstream of the ALU.
- Holds the 16 general-purpose registers and drives both ALU operands: R1 (source) and R2 (destination).
- Accepts the ALU writeback and the 5-bit ALU flags, and latches them into a processor status register (PSR).
- Drives the ALU carry-in from the latched PSR carry bit.

Parameters:
- DATA_W, 16, register and operand width
- ADDR_W, 4, register select width
- NREGS, 16, number of registers (must equal 2**ADDR_W)
- FLAG_W, 5, flag/PSR width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- src_sel  input  ADDR_W  register index driven onto r1_out (ALU R1, source)
- dst_sel  input  ADDR_W  register index driven onto r2_out (ALU R2, destination)
- r1_out  output  DATA_W  source operand to ALU
- r2_out  output  DATA_W  destination operand to ALU
- wr_en  input  1  register write enable
- wr_sel  input  ADDR_W  register index to write
- wr_data  input  DATA_W  writeback data (ALU aluOut or load data)
- flags_in  input  FLAG_W  ALU flags: bit0 C, bit1 L, bit2 F (overflow), bit3 N, bit4 Z
- flags_we  input  FLAG_W  per-bit PSR write mask
- psr  output  FLAG_W  current latched PSR
- cin  output  1  carry-in to ALU, equals psr[0]
- dbg_sel  input  ADDR_W  debug read index
- dbg_out  output  DATA_W  debug read data, raw register contents with no bypass

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (reset).
- Reset:
  - On a rising edge with reset=1, all NREGS registers clear to 16'h0000 and psr clears to 5'b00000.
  - reset overrides wr_en and flags_we in the same cycle.
  - After reset, r1_out, r2_out and dbg_out read 0 and cin=0.
  - Reset asserted mid-sequence discards any write presented that cycle.
- Register write:
  - On a rising edge with reset=0 and wr_en=1, reg[wr_sel] <= wr_data.
  - All registers, including r0, are writable; there is no hard-wired zero.
  - With wr_en=0, no register changes.
- Read:
  - r1_out and r2_out are combinational (zero latency).
  - Write-through bypass: if wr_en=1 and wr_sel==src_sel, r1_out=wr_data in the same cycle; same rule for dst_sel and r2_out.
  - Both ports may bypass simultaneously when src_sel==dst_sel==wr_sel.
  - Otherwise each port reads the stored register.
  - dbg_out never bypasses; it shows the pre-edge value.
- PSR update:
  - On a rising edge with reset=0, for each bit i: psr[i] <= flags_we[i] ? flags_in[i] : psr[i].
  - Unmasked bits hold their value.
  - flags_we=0 means the PSR holds entirely.
- cin:
  - cin = psr[0], registered, with no bypass from flags_in.
  - Consequence: an ADDC/SUBC consumes the carry produced by the previous instruction, which must have been written at least one edge earlier.
- Simultaneous events:
  - A register write and a PSR update in the same edge are independent and both take effect.
  - Writing the same register on consecutive edges: the last write wins, and the bypass always reflects the current-cycle wr_data.
- Width rules:
  - wr_data is stored unmodified.
  - Index values are always in range because NREGS = 2**ADDR_W.
  - No X on outputs after reset for any select value.

Test Plan:
- Reset: write reg5=16'hBEEF, then assert reset one cycle with wr_en=1, wr_sel=5, wr_data=16'h1234 -> after the edge, reg5=0, dbg_out(5)=0, psr=0, cin=0.
- Write/read: write reg3=16'h00A5, then reg7=16'hFF00 on the next edge; set src_sel=3, dst_sel=7 with wr_en=0 -> r1_out=16'h00A5, r2_out=16'hFF00.
- Bypass: reg2 holds 16'h0001; drive wr_en=1, wr_sel=2, wr_data=16'h7FFF with src_sel=dst_sel=2 -> before the edge, r1_out=r2_out=16'h7FFF and dbg_out(2)=16'h0001; after the edge, dbg_out(2)=16'h7FFF.
- PSR mask: psr=0; flags_in=5'b11111, flags_we=5'b10001 -> after the edge, psr=5'b10001 and cin=1; then flags_in=0, flags_we=5'b00100 -> psr remains 5'b10001.
- Carry chain: cycle 1, flags_in=5'b00001 with flags_we=5'b00001 -> cin stays 0 during cycle 1 (no bypass) and becomes 1 in cycle 2; cycle 2, flags_in=0 with flags_we=5'b00001 -> cin=0 in cycle 3.
- Sweep: write reg[i]=16'h1111*i (truncated to 16 bits) for i=0..15, then read every pair (src_sel, dst_sel) -> each output matches its stored value; no bypass occurs because wr_en=0.
